// File: rtl/output_pixel_divider_pkg.sv
// Shared widths, constants and the stage bundle for the pixel divider.
// Imported by the divide stage and the top.
package output_pixel_divider_pkg;

  localparam int NUM_W   = 28;
  localparam int DEN_W   = 20;
  localparam int Q_W     = 8;
  localparam int LATENCY = Q_W + 1;

  localparam logic [Q_W-1:0] QMAX = 8'hFF;

  typedef struct packed {
    logic             vld;
    logic             sat;
    logic [NUM_W-1:0] rem;
    logic [DEN_W-1:0] den;
    logic [Q_W-1:0]   quo;
  } stage_t;

endpackage

// File: rtl/DW01_add.sv
// Behavioural stand-in for the DesignWare adder: SUM/CO = A + B + CI.
// Ports: A, B (width), CI; SUM (width), CO carry out.
module DW01_add #(
  parameter int width = 8
) (
  input  logic [width-1:0] A,
  input  logic [width-1:0] B,
  input  logic             CI,
  output logic [width-1:0] SUM,
  output logic             CO
);

  assign {CO, SUM} = (width+1)'(A) + (width+1)'(B)
                   + (width+1)'(CI);

endmodule

// File: rtl/output_pixel_divider_div_stage.sv
// One restoring-divide step: resolves quotient bit SHIFT.
// Ports: clock, reset_n, i_stg (incoming bundle), o_stg (registered).
module output_pixel_divider_div_stage
  import output_pixel_divider_pkg::*;
#(
  parameter int SHIFT = 0
) (
  input  logic   clock,
  input  logic   reset_n,
  input  stage_t i_stg,
  output stage_t o_stg
);

  logic [NUM_W:0] w_a;
  logic [NUM_W:0] w_dsh;
  logic [NUM_W:0] w_t;
  logic           w_co;
  logic           w_nb;
  logic [Q_W-1:0] w_q;

  assign w_a   = {1'b0, i_stg.rem};
  assign w_dsh = (NUM_W+1)'(i_stg.den) << SHIFT;

  DW01_add #(.width(NUM_W+1)) u_sub (
    .A   (w_a),
    .B   (~w_dsh),
    .CI  (1'b1),
    .SUM (w_t),
    .CO  (w_co)
  );

  // Carry out means no borrow; the top bit is then always clear.
  assign w_nb = w_co & ~w_t[NUM_W];
  assign w_q  = i_stg.quo | (Q_W'(w_nb) << SHIFT);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      o_stg <= '0;
    end else if (!i_stg.vld) begin
      o_stg <= '0;
    end else begin
      o_stg.vld <= 1'b1;
      o_stg.sat <= i_stg.sat;
      o_stg.den <= i_stg.den;
      o_stg.quo <= w_q;
      o_stg.rem <= w_nb ? w_t[NUM_W-1:0] : i_stg.rem;
    end
  end

endmodule

// File: rtl/output_pixel_divider.sv
// Pipelined numerator/denominator divider producing equalized pixels.
// Ports: clock, reset_n, DataIn/StartIn, DenomIn/DenomLoad -> DataOut, StartOut, OutCount.
module output_pixel_divider
  import output_pixel_divider_pkg::*;
(
  input  logic             clock,
  input  logic             reset_n,
  input  logic [NUM_W-1:0] DataIn,
  input  logic             StartIn,
  input  logic [DEN_W-1:0] DenomIn,
  input  logic             DenomLoad,
  output logic [Q_W-1:0]   DataOut,
  output logic             StartOut,
  output logic [DEN_W-1:0] OutCount
);

  logic [DEN_W-1:0] r_den;
  logic [DEN_W-1:0] r_cnt;
  stage_t           r_cap;
  stage_t           w_pipe [Q_W+1];
  logic             w_sat;
  stage_t           w_last;

  // Quotient would not fit in Q_W bits (or divide by zero).
  assign w_sat = (r_den == '0) ||
                 ({1'b0, DataIn} >=
                  (NUM_W+1)'({r_den, {Q_W{1'b0}}}));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_cap <= '0;
      r_den <= '0;
    end else begin
      if (StartIn) begin
        r_cap.vld <= 1'b1;
        r_cap.sat <= w_sat;
        r_cap.rem <= DataIn;
        r_cap.den <= r_den;
        r_cap.quo <= '0;
      end else begin
        r_cap <= '0;
      end
      if (DenomLoad) r_den <= DenomIn;
    end
  end

  assign w_pipe[0] = r_cap;

  for (genvar k = 0; k < Q_W; k++) begin : g_stage
    output_pixel_divider_div_stage #(
      .SHIFT(Q_W-1-k)
    ) u_stage (
      .clock   (clock),
      .reset_n (reset_n),
      .i_stg   (w_pipe[k]),
      .o_stg   (w_pipe[k+1])
    );
  end

  assign w_last = w_pipe[Q_W];

  // A pulse coinciding with a reload belongs to the new frame.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
    end else if (DenomLoad) begin
      r_cnt <= DEN_W'(w_last.vld);
    end else if (w_last.vld) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign StartOut = w_last.vld;
  assign DataOut  = !w_last.vld ? '0 :
                    w_last.sat  ? QMAX : w_last.quo;
  assign OutCount = r_cnt;

endmodule

// File: tb/tb_output_pixel_divider.sv
// Randomized + directed bench for output_pixel_divider.
// Reference: per-edge schedule of expected quotients from plain division.
module tb_output_pixel_divider;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [27:0] DataIn = '0;
  logic        StartIn = 1'b0;
  logic [19:0] DenomIn = '0;
  logic        DenomLoad = 1'b0;
  logic [7:0]  DataOut;
  logic        StartOut;
  logic [19:0] OutCount;

  output_pixel_divider dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .DataIn    (DataIn),
    .StartIn   (StartIn),
    .DenomIn   (DenomIn),
    .DenomLoad (DenomLoad),
    .DataOut   (DataOut),
    .StartOut  (StartOut),
    .OutCount  (OutCount)
  );

  always #5 clock = ~clock;

  int          n_vec = 0;
  int          n_err = 0;
  int          cyc = 0;
  longint      m_den = 0;
  logic [19:0] m_cnt = '0;
  bit          exp_v [int];
  logic [7:0]  exp_d [int];

  task automatic chk(string tag, logic [31:0] got,
                     logic [31:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s @cyc %0d: observed %0d expected %0d",
             tag, cyc, got, exp);
    end
  endtask

  function automatic logic [7:0] ref_q(longint num, longint den);
    if (den == 0 || num >= den * 256) return 8'd255;
    return 8'(num / den);
  endfunction

  // One clock: drive, take the edge, advance the model, check.
  task automatic step(bit st, longint data, bit ld, longint dv);
    bit prev_v;
    StartIn   = st;
    DataIn    = 28'(data);
    DenomLoad = ld;
    DenomIn   = 20'(dv);
    @(posedge clock);
    cyc++;
    prev_v = exp_v.exists(cyc-1) ? exp_v[cyc-1] : 1'b0;
    if (ld) m_cnt = prev_v ? 20'd1 : 20'd0;
    else if (prev_v) m_cnt = m_cnt + 20'd1;
    if (st) begin
      exp_v[cyc+8] = 1'b1;
      exp_d[cyc+8] = ref_q(data, m_den);
    end
    if (ld) m_den = dv;
    #1;
    if (exp_v.exists(cyc)) begin
      chk("startout", {31'd0, StartOut}, 32'd1);
      chk("dataout", {24'd0, DataOut}, {24'd0, exp_d[cyc]});
    end else begin
      chk("startout_idle", {31'd0, StartOut}, 32'd0);
      chk("dataout_idle", {24'd0, DataOut}, 32'd0);
    end
    chk("outcount", {12'd0, OutCount}, {12'd0, m_cnt});
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #2;
    chk("rst_startout", {31'd0, StartOut}, 32'd0);
    chk("rst_dataout", {24'd0, DataOut}, 32'd0);
    chk("rst_outcount", {12'd0, OutCount}, 32'd0);
    exp_v.delete();
    exp_d.delete();
    m_cnt = '0;
    m_den = 0;
    reset_n = 1'b1;
  endtask

  initial begin
    longint den;
    longint num;
    #2;
    do_reset();
    @(posedge clock);
    #1;

    // Single operand.
    step(0, 0, 1, 1000);
    step(1, 127500, 0, 0);
    idle(10);

    // Back-to-back stream.
    step(0, 0, 1, 1000);
    step(1, 0, 0, 0);
    step(1, 255000, 0, 0);
    step(1, 1000, 0, 0);
    step(1, 254999, 0, 0);
    idle(10);
    chk("count4", {12'd0, OutCount}, 32'd4);

    // Zero denominator then over-range numerator.
    step(0, 0, 1, 0);
    step(1, 5, 1, 1000);
    step(1, 300000, 0, 0);
    idle(10);

    // Denominator switch mid-stream.
    step(0, 0, 1, 1000);
    step(1, 200000, 1, 500);
    step(1, 200000, 0, 0);
    idle(7);
    step(0, 0, 1, 500);
    idle(3);

    // Gapped input.
    step(0, 0, 1, 777);
    step(1, 100000, 0, 0);
    step(0, 0, 0, 0);
    step(1, 777, 0, 0);
    step(0, 0, 0, 0);
    step(1, 198134, 0, 0);
    idle(10);

    // Reset with operands in flight.
    step(1, 50000, 0, 0);
    step(1, 60000, 0, 0);
    step(1, 70000, 0, 0);
    idle(4);
    do_reset();
    idle(12);
    chk("count_after_rst", {12'd0, OutCount}, 32'd0);

    // Randomized traffic.
    step(0, 0, 1, 1234);
    den = 1234;
    for (int i = 0; i < 400; i++) begin
      bit ld;
      bit st;
      longint dv;
      ld = ($urandom_range(0, 19) == 0);
      st = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 3))
        0: dv = 0;
        1: dv = $urandom_range(1, 16);
        default: dv = $urandom_range(1, 20'hFFFFF);
      endcase
      if ($urandom_range(0, 3) == 0)
        num = longint'($urandom) & 64'hFFF_FFFF;
      else
        num = den * $urandom_range(0, 260) +
              $urandom_range(0, 3);
      if (num > 64'hFFF_FFFF) num = 64'hFFF_FFFF;
      step(st, num, ld, dv);
      if (ld) den = dv;
    end
    idle(10);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
